// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for the 5-stage pipelined CPU.
//
// The controller keeps its own shadow copy of the destination information of
// in-flight instructions. It therefore needs only the ID-stage decode fields
// and the data-memory ready handshake. Operand mux selects are computed while
// the consumer sits in ID. They are registered on the edge that moves the
// consumer into EX.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous, active-low reset
//   id_valid_i     ID stage holds a real instruction
//   id_rs_i        ID source register A
//   id_rt_i        ID source register B
//   id_use_rs_i    ID instruction reads rs
//   id_use_rt_i    ID instruction reads rt
//   id_regwrite_i  ID instruction writes a register
//   id_rd_i        ID final destination register
//   id_memread_i   ID instruction is a load
//   id_memwrite_i  ID instruction is a store
//   dmem_ready_i   data memory completes the MEM-stage access this cycle
//   fwd_a_o        operand-A select for the instruction now in EX
//   fwd_b_o        operand-B select for the instruction now in EX
//   stall_o        hold PC and IF/ID
//   bubble_o       load a NOP into ID/EX
//   freeze_o       hold every pipeline register
//
// Select encoding
//   00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback data,
//   11 RET hold value (the data written one cycle earlier).
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter bit LOADUSE_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_regwrite_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              dmem_ready_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              freeze_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  // Full slot payload. It is needed while an instruction can still cause a
  // load-use stall (EX) or a memory wait (MEM).
  typedef struct packed {
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] dest;
  } info_t;

  // Producer-only payload. By WB only the destination matters.
  typedef struct packed {
    logic              regwrite;
    logic [REG_AW-1:0] dest;
  } prod_t;

  // Valid bits and selects are control and are reset. Payload fields are
  // meaningless while the matching valid bit is low, so they carry no reset.
  logic       ex_vld_q,  ex_vld_d;
  logic       mem_vld_q, mem_vld_d;
  logic       wb_vld_q,  wb_vld_d;
  logic [1:0] fwd_a_q,   fwd_a_d;
  logic [1:0] fwd_b_q,   fwd_b_d;

  info_t ex_info_q;
  info_t mem_info_q;
  prod_t wb_info_q;
  info_t id_info;

  // The RET slot is not stored. A producer in WB while the consumer is in ID
  // reaches RET exactly when the consumer reaches EX, so a WB-slot hit already
  // yields the RET select. Anything older is visible in the register file.
  logic hit_ex_a,  hit_ex_b;
  logic hit_mem_a, hit_mem_b;
  logic hit_wb_a,  hit_wb_b;
  logic [1:0] sel_a, sel_b;
  logic freeze, loaduse;

  function automatic logic slot_hit(
    input logic              vld,
    input logic              regwrite,
    input logic [REG_AW-1:0] dest,
    input logic [REG_AW-1:0] src,
    input logic              use_src
  );
    // Register 0 is hard-wired, so it is never forwarded.
    return vld & regwrite & (dest == src) & (src != '0) & use_src;
  endfunction

  function automatic logic [1:0] pick_sel(
    input logic h_ex,
    input logic h_mem,
    input logic h_wb
  );
    // The youngest producer wins.
    if (h_ex)       return SEL_EXM;
    else if (h_mem) return SEL_MWB;
    else if (h_wb)  return SEL_RET;
    else            return SEL_RF;
  endfunction

  always_comb begin
    id_info.regwrite = id_regwrite_i;
    id_info.memread  = id_memread_i;
    id_info.memwrite = id_memwrite_i;
    id_info.dest     = id_rd_i;
  end

  always_comb begin
    hit_ex_a  = slot_hit(ex_vld_q,  ex_info_q.regwrite,  ex_info_q.dest,  id_rs_i, id_use_rs_i);
    hit_ex_b  = slot_hit(ex_vld_q,  ex_info_q.regwrite,  ex_info_q.dest,  id_rt_i, id_use_rt_i);
    hit_mem_a = slot_hit(mem_vld_q, mem_info_q.regwrite, mem_info_q.dest, id_rs_i, id_use_rs_i);
    hit_mem_b = slot_hit(mem_vld_q, mem_info_q.regwrite, mem_info_q.dest, id_rt_i, id_use_rt_i);
    hit_wb_a  = slot_hit(wb_vld_q,  wb_info_q.regwrite,  wb_info_q.dest,  id_rs_i, id_use_rs_i);
    hit_wb_b  = slot_hit(wb_vld_q,  wb_info_q.regwrite,  wb_info_q.dest,  id_rt_i, id_use_rt_i);
    sel_a     = pick_sel(hit_ex_a, hit_mem_a, hit_wb_a);
    sel_b     = pick_sel(hit_ex_b, hit_mem_b, hit_wb_b);
  end

  // A memory wait masks load-use. The load-use is seen again after release.
  always_comb begin
    freeze  = mem_vld_q & (mem_info_q.memread | mem_info_q.memwrite) & ~dmem_ready_i;
    loaduse = LOADUSE_EN & id_valid_i & ex_vld_q & ex_info_q.memread
            & (hit_ex_a | hit_ex_b) & ~freeze;
  end

  always_comb begin
    ex_vld_d  = ex_vld_q;
    mem_vld_d = mem_vld_q;
    wb_vld_d  = wb_vld_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (!freeze) begin
      mem_vld_d = ex_vld_q;
      wb_vld_d  = mem_vld_q;
      if (loaduse) begin
        // The bubble enters EX. The consumer stays in ID and re-evaluates
        // against the load, which has moved to MEM.
        ex_vld_d = 1'b0;
        fwd_a_d  = SEL_RF;
        fwd_b_d  = SEL_RF;
      end else begin
        ex_vld_d = id_valid_i;
        fwd_a_d  = sel_a;
        fwd_b_d  = sel_b;
      end
    end
  end

  // ID -> EX -> MEM -> WB boundary: control state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
      fwd_a_q   <= SEL_RF;
      fwd_b_q   <= SEL_RF;
    end else begin
      ex_vld_q  <= ex_vld_d;
      mem_vld_q <= mem_vld_d;
      wb_vld_q  <= wb_vld_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  // ID -> EX -> MEM -> WB boundary: slot payload. A bubble may carry stale
  // payload into EX because its valid bit is low.
  always_ff @(posedge clk_i) begin
    if (!freeze) begin
      ex_info_q          <= id_info;
      mem_info_q         <= ex_info_q;
      wb_info_q.regwrite <= mem_info_q.regwrite;
      wb_info_q.dest     <= mem_info_q.dest;
    end
  end

  assign fwd_a_o  = fwd_a_q;
  assign fwd_b_o  = fwd_b_q;
  assign freeze_o = freeze;
  assign bubble_o = loaduse;
  assign stall_o  = freeze | loaduse;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed table of ID-stage instructions, one row per clock cycle. Each row
// holds the expected outputs for that cycle. The fwd_* outputs describe the
// instruction that entered EX at the previous edge. stall/bubble/freeze
// describe the current cycle. A hand-written tail drops reset mid-freeze.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite;
  logic          dmem_ready;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, bubble, freeze;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(AW), .LOADUSE_EN(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_use_rs_i  (id_use_rs),
    .id_use_rt_i  (id_use_rt),
    .id_regwrite_i(id_regwrite),
    .id_rd_i      (id_rd),
    .id_memread_i (id_memread),
    .id_memwrite_i(id_memwrite),
    .dmem_ready_i (dmem_ready),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .stall_o      (stall),
    .bubble_o     (bubble),
    .freeze_o     (freeze)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] rs, rt, rd;
    logic          urs, urt, rw, mr, mw, rdy;
    logic [1:0]    fa, fb;
    logic          st, bb, fz;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int rw, int rd,
                              int mr, int mw, int rdy, int fa, int fb, int st, int bb, int fz);
    vec_t r;
    r.v  = v[0];   r.rs  = rs[AW-1:0]; r.rt  = rt[AW-1:0];
    r.urs = urs[0]; r.urt = urt[0];     r.rw  = rw[0];
    r.rd = rd[AW-1:0]; r.mr = mr[0];   r.mw  = mw[0]; r.rdy = rdy[0];
    r.fa = fa[1:0]; r.fb = fb[1:0];    r.st  = st[0]; r.bb  = bb[0]; r.fz = fz[0];
    return r;
  endfunction

  task automatic apply(input vec_t r);
    id_valid    = r.v;   id_rs      = r.rs;  id_rt       = r.rt;
    id_use_rs   = r.urs; id_use_rt  = r.urt; id_regwrite = r.rw;
    id_rd       = r.rd;  id_memread = r.mr;  id_memwrite = r.mw;
    dmem_ready  = r.rdy;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic st, input logic bb, input logic fz);
    check({tag, ".fwd_a"},  fwd_a,         fa);
    check({tag, ".fwd_b"},  fwd_b,         fb);
    check({tag, ".stall"},  {1'b0, stall},  {1'b0, st});
    check({tag, ".bubble"}, {1'b0, bubble}, {1'b0, bb});
    check({tag, ".freeze"}, {1'b0, freeze}, {1'b0, fz});
  endtask

  initial begin
    vec_t nop;
    nop = mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0);

    // Back-to-back ALU forward.
    vq.push_back(mk(1,0,0,0,0,1,3,0,0,1, 0,0,0,0,0));  // add $3
    vq.push_back(mk(1,3,0,1,0,1,7,0,0,1, 0,0,0,0,0));  // sub rs=$3
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0));  // sub in EX: 01
    // Distance 2.
    vq.push_back(mk(1,0,0,0,0,1,5,0,0,1, 0,0,0,0,0));  // producer $5
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));  // filler
    vq.push_back(mk(1,0,5,0,1,1,20,0,0,1, 0,0,0,0,0)); // consumer rt=$5
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,2,0,0,0));  // fwd_b 10
    // Distance 3.
    vq.push_back(mk(1,0,0,0,0,1,5,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,5,0,1,1,20,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,3,0,0,0));  // fwd_b 11
    // Distance 4: register file.
    vq.push_back(mk(1,0,0,0,0,1,5,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,5,0,1,1,20,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));  // fwd_b 00
    // Load-use: one stall cycle, then 10.
    vq.push_back(mk(1,0,0,0,0,1,8,1,0,1, 0,0,0,0,0));  // lw $8
    vq.push_back(mk(1,8,0,1,0,1,21,0,0,1, 0,0,1,1,0)); // add rs=$8: stall+bubble
    vq.push_back(mk(1,8,0,1,0,1,21,0,0,1, 0,0,0,0,0)); // bubble in EX, add proceeds
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 2,0,0,0,0));  // add in EX: 10
    // Priority: youngest of two $4 producers.
    vq.push_back(mk(1,0,0,0,0,1,4,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,0,0,1,4,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,4,0,1,0,1,22,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0));
    // $0 is never forwarded.
    vq.push_back(mk(1,0,0,0,0,1,0,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,0,0,1,1,1,22,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0));
    // Memory wait with a coincident load-use.
    vq.push_back(mk(1,0,0,0,0,1,6,0,0,1, 0,0,0,0,0));  // alu $6
    vq.push_back(mk(1,0,0,0,0,1,10,1,0,1, 0,0,0,0,0)); // lw A $10
    vq.push_back(mk(1,6,0,1,0,1,11,1,0,1, 0,0,0,0,0)); // lw B $11 rs=$6
    vq.push_back(mk(1,11,0,1,0,1,12,0,0,0, 2,0,1,0,1)); // A waits: freeze 1
    vq.push_back(mk(1,11,0,1,0,1,12,0,0,0, 2,0,1,0,1)); // freeze 2
    vq.push_back(mk(1,11,0,1,0,1,12,0,0,0, 2,0,1,0,1)); // freeze 3
    vq.push_back(mk(1,11,0,1,0,1,12,0,0,1, 2,0,1,1,0)); // release: load-use on B
    vq.push_back(mk(1,11,0,1,0,1,12,0,0,1, 0,0,0,0,0)); // bubble in EX
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,1, 2,0,0,0,0));  // add in EX: 10
    // Store wait.
    vq.push_back(mk(1,0,0,0,0,0,0,0,1,1, 0,0,0,0,0));  // sw
    vq.push_back(nop);
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));  // sw in MEM, not ready
    vq.push_back(nop);
    // Set-up for reset mid-freeze.
    vq.push_back(mk(1,0,0,0,0,1,7,0,0,1, 0,0,0,0,0));  // alu $7
    vq.push_back(mk(1,0,0,0,0,1,13,1,0,1, 0,0,0,0,0)); // lw $13
    vq.push_back(mk(1,7,0,1,0,1,23,0,0,1, 0,0,0,0,0)); // rs=$7
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,0,1,0,1));  // lw waits, EX has 10

    rst_n = 1'b0;
    apply(nop);
    repeat (2) @(negedge clk);
    #1;
    check_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      apply(vq[i]);
      #1;
      check_all($sformatf("row%0d", i), vq[i].fa, vq[i].fb, vq[i].st, vq[i].bb, vq[i].fz);
    end

    // Reset dropped while frozen, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_midfreeze", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1,13,0,1,0,1,24,0,0,1, 0,0,0,0,0));       // reads $13 of the flushed load
    #1;
    check_all("post_rst_id", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    apply(nop);
    #1;
    check_all("post_rst_ex", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
